// File: rtl/mul4_rr_sched.sv
// rtl/mul4_rr_sched.sv - shift-and-add multiplier shared by two requesters via round-robin grant
module mul4_rr_sched #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req,
    input  logic [W-1:0]     a0,
    input  logic [W-1:0]     b0,
    input  logic [W-1:0]     a1,
    input  logic [W-1:0]     b1,
    output logic [1:0]       ack,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [2*W-1:0]   product
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    mcand;
    logic [W-1:0]    acc_hi;
    logic [W-1:0]    acc_lo;
    logic [CW-1:0]   cnt;
    logic            cur_id;
    logic            last_grant;
    logic            grant;
    logic [W:0]      sum;

    // Ties go to the requester not served last; a lone requester always wins.
    always_comb begin
        grant = (req == 2'b11) ? ~last_grant : req[1];
        ack   = 2'b00;
        if (rst_n && state == IDLE && req != 2'b00) begin
            ack = grant ? 2'b10 : 2'b01;
        end
        sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, mcand}) : {1'b0, acc_hi};
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mcand      <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
            cnt        <= '0;
            cur_id     <= 1'b0;
            last_grant <= 1'b1;
            done       <= 1'b0;
            done_id    <= 1'b0;
            product    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        mcand      <= grant ? a1 : a0;
                        acc_hi     <= '0;
                        acc_lo     <= grant ? b1 : b0;
                        cur_id     <= grant;
                        last_grant <= grant;
                        cnt        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    // The adder carry becomes the top bit of the shifted accumulator.
                    {acc_hi, acc_lo} <= {sum, acc_lo[W-1:1]};
                    cnt              <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        product <= {sum, acc_lo[W-1:1]};
                        done_id <= cur_id;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul4_rr_sched.sv
// tb/tb_mul4_rr_sched.sv - self-checking bench for mul4_rr_sched
module tb_mul4_rr_sched;
    localparam int W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       req = 2'b00;
    logic [W-1:0]     a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic [1:0]       ack;
    logic             busy, done, done_id;
    logic [2*W-1:0]   product;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    mul4_rr_sched #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack(ack), .busy(busy), .done(done), .done_id(done_id), .product(product)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a job granted at cycle t occupies the engine until t+W+2
    // and reports a*b at t+W+1. Inputs change only just after posedge.
    int             m_free = 0, m_start = -100, m_due = -1;
    logic           m_last = 1'b1;
    logic [2*W-1:0] m_pend_p = '0, m_prod = '0;
    logic           m_pend_id = 1'b0, m_id = 1'b0;

    always @(negedge clk) begin
        logic [1:0] e_ack;
        logic       g;
        if (!rst_n) begin
            m_last = 1'b1; m_free = 0; m_start = -100; m_due = -1;
            m_prod = '0; m_id = 1'b0;
            chk("rst_ack", ack, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_done_id", done_id, 0);
            chk("rst_product", product, 0);
        end else begin
            e_ack = 2'b00;
            if (cyc >= m_free && req != 2'b00) begin
                g = (req == 2'b11) ? !m_last : req[1];
                e_ack = g ? 2'b10 : 2'b01;
                m_last = g;
                m_start = cyc;
                m_due = cyc + W + 1;
                m_free = cyc + W + 2;
                m_pend_p = g ? (2*W)'(a1) * (2*W)'(b1) : (2*W)'(a0) * (2*W)'(b0);
                m_pend_id = g;
            end
            chk("ack", ack, e_ack);
            chk("busy", busy, (cyc > m_start && cyc < m_free) ? 1 : 0);
            chk("done", done, (cyc == m_due) ? 1 : 0);
            if (cyc == m_due) begin
                m_prod = m_pend_p;
                m_id = m_pend_id;
            end
            chk("product", product, m_prod);
            chk("done_id", done_id, m_id);
        end
    end

    task automatic wait_ack(output logic [1:0] a);
        logic seen = 1'b0;
        a = 2'b00;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                a = ack;
                seen = 1'b1;
            end
        end
        chk("ack_seen", seen, 1);
    endtask

    task automatic wait_done(output logic [2*W-1:0] p, output logic id);
        logic seen = 1'b0;
        p = '0;
        id = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                p = product;
                id = done_id;
                seen = 1'b1;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic do_op(input logic [1:0] r, input logic [W-1:0] x0, y0, x1, y1,
                         output logic [2*W-1:0] p, output logic id);
        logic [1:0] a;
        @(posedge clk); #2;
        req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        wait_ack(a);
        @(posedge clk); #2;
        req = 2'b00;
        wait_done(p, id);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0; req = 2'b00;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0]     r;
        logic [W-1:0]   x0, y0, x1, y1;
        logic           eid;
        logic [2*W-1:0] ep;
    } vec_t;

    vec_t             vecs[6];
    logic [2*W-1:0]   p;
    logic             id;
    logic [1:0]       a;
    int               ack_cyc[4];
    logic             ack_id[4];
    int               n_ack, n_done, n_bad;

    initial begin
        vecs[0] = '{2'b01,  3,  5,  0,  0, 1'b0, 8'd15};
        vecs[1] = '{2'b10,  0,  0, 15, 15, 1'b1, 8'hE1};
        vecs[2] = '{2'b01,  0, 13,  0,  0, 1'b0, 8'd0};
        vecs[3] = '{2'b01, 13,  0,  0,  0, 1'b0, 8'd0};
        vecs[4] = '{2'b10,  4,  4,  7, 11, 1'b1, 8'd77};
        vecs[5] = '{2'b01, 15, 15,  2,  2, 1'b0, 8'hE1};

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].r, vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, p, id);
            chk($sformatf("vec%0d_product", i), p, vecs[i].ep);
            chk($sformatf("vec%0d_id", i), id, vecs[i].eid);
        end

        // Tie held high: grants alternate 0,1,0 starting with 0 after reset.
        do_reset();
        @(posedge clk); #2;
        req = 2'b11; a0 = 2; b0 = 7; a1 = 9; b1 = 9;
        n_ack = 0; n_done = 0;
        for (int i = 0; i < 60 && n_done < 3; i++) begin
            @(negedge clk);
            if (ack != 2'b00 && n_ack < 4) begin
                ack_cyc[n_ack] = cyc;
                ack_id[n_ack] = ack[1];
                n_ack++;
            end
            if (done) begin
                chk("tie_id", done_id, (n_done == 1) ? 1 : 0);
                chk("tie_product", product, (n_done == 1) ? 81 : 14);
                n_done++;
            end
        end
        chk("tie_done_count", n_done, 3);
        chk("tie_first_grant", ack_id[0], 0);
        chk("tie_second_grant", ack_id[1], 1);
        chk("tie_third_grant", ack_id[2], 0);
        chk("tie_spacing_01", ack_cyc[1] - ack_cyc[0], W + 2);
        chk("tie_spacing_12", ack_cyc[2] - ack_cyc[1], W + 2);
        @(posedge clk); #2 req = 2'b00;
        repeat (W + 4) @(posedge clk);

        // Exhaustive sweep on requester 0.
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_op(2'b01, W'(x), W'(y), '0, '0, p, id);
                chk($sformatf("sweep_%0dx%0d", x, y), p, x * y);
            end
        end

        // Reset while the engine is in its second RUN cycle.
        do_reset();
        @(posedge clk); #2;
        req = 2'b01; a0 = 11; b0 = 6;
        wait_ack(a);
        @(posedge clk); #2 req = 2'b00;
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_product", product, 0);
        n_bad = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) n_bad++;
        end
        chk("abort_no_done", n_bad, 0);
        @(posedge clk); #2 req = 2'b11;
        wait_ack(a);
        chk("abort_regrant", a, 2'b01);
        @(posedge clk); #2 req = 2'b00;
        wait_done(p, id);
        chk("abort_regrant_product", p, 66);

        // Changes while busy are ignored; the waiting request follows done.
        @(posedge clk); #2;
        req = 2'b01; a0 = 5; b0 = 6;
        wait_ack(a);
        chk("busy_first_ack", a, 2'b01);
        @(posedge clk); #2 req = 2'b00; a0 = 15; b0 = 15;
        @(posedge clk); #2 req = 2'b10; a1 = 3; b1 = 4; a0 = 1;
        @(posedge clk); #2 req = 2'b11; a0 = 0;
        wait_done(p, id);
        chk("busy_first_product", p, 30);
        chk("busy_first_id", id, 0);
        wait_ack(a);
        chk("busy_second_ack", a, 2'b10);
        @(posedge clk); #2 req = 2'b00;
        wait_done(p, id);
        chk("busy_second_product", p, 12);
        chk("busy_second_id", id, 1);

        // Random traffic checked by the reference model.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #2;
            req = 2'($urandom);
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
        end
        @(posedge clk); #2 req = 2'b00;
        repeat (W + 4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
